// File: rtl/regfile_dump.sv
// Three-port MIPS register file (r0 hard-wired to zero) with a valid/ready dump
// engine that streams every register out for trace/debug alongside normal traffic.
module regfile_dump #(
   parameter int Width = 32,
   parameter int Depth = 32,
   parameter int AddrW = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [AddrW-1:0] ra1,
   output logic [Width-1:0] rd1,
   input  logic [AddrW-1:0] ra2,
   output logic [Width-1:0] rd2,
   input  logic             we,
   input  logic [AddrW-1:0] wa,
   input  logic [Width-1:0] wd,
   input  logic             dump_start,
   output logic             dump_busy,
   output logic             dump_valid,
   input  logic             dump_ready,
   output logic [AddrW-1:0] dump_addr,
   output logic [Width-1:0] dump_data,
   output logic             dump_done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [AddrW-1:0] LAST = AddrW'(Depth - 1);

   logic [Width-1:0] regs [Depth];
   logic [1:0]       state;

   // Shared read rule: r0 reads zero, an in-flight write is forwarded.
   function automatic logic [Width-1:0] read_port(input logic [AddrW-1:0] ra);
      if (ra == '0)
         return '0;
      if (we && (wa == ra))
         return wd;
      return regs[ra];
   endfunction

   always_comb begin
      rd1       = read_port(ra1);
      rd2       = read_port(ra2);
      dump_data = read_port(dump_addr);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < Depth; i++)
            regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         dump_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (dump_start) begin
                  state     <= RUN;
                  dump_addr <= '0;
               end
            end
            RUN: begin
               if (dump_ready) begin
                  if (dump_addr == LAST)
                     state <= DONE;
                  else
                     dump_addr <= dump_addr + AddrW'(1);
               end
            end
            DONE: begin
               state     <= IDLE;
               dump_addr <= '0;
            end
            default: begin
               state     <= IDLE;
               dump_addr <= '0;
            end
         endcase
      end
   end

   // Handshake outputs decode straight from state so reset clears them at once.
   assign dump_valid = (state == RUN);
   assign dump_busy  = (state == RUN) || (state == DONE);
   assign dump_done  = (state == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: read/write/bypass checks plus dump runs
// with free-flowing, toggled, stalled-with-write and reset-interrupted consumers.
module tb_regfile_dump;

   localparam int DEPTH = 32;

   logic        clock;
   logic        reset_n;
   logic [4:0]  ra1, ra2, wa, dump_addr;
   logic [31:0] rd1, rd2, wd, dump_data;
   logic        we, dump_start, dump_busy, dump_valid, dump_ready, dump_done;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } beat_t;

   beat_t       sb [$];
   logic [31:0] mdl [DEPTH];
   int          n_cmp = 0;
   int          n_bad = 0;

   regfile_dump #(.Width(32), .Depth(DEPTH), .AddrW(5)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .ra1        (ra1),
      .rd1        (rd1),
      .ra2        (ra2),
      .rd2        (rd2),
      .we         (we),
      .wa         (wa),
      .wd         (wd),
      .dump_start (dump_start),
      .dump_busy  (dump_busy),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_done  (dump_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Beats are taken just before the edge that transfers them.
   always @(negedge clock) begin
      beat_t b;
      #4;
      if (reset_n && dump_valid && dump_ready) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_beat", 32'(dump_addr), 32'hFFFF_FFFF);
         end else begin
            b = sb.pop_front();
            check_eq("beat_addr", 32'(dump_addr), 32'(b.addr));
            check_eq("beat_data", dump_data, b.data);
         end
      end
   end

   task automatic read_all(input string tag);
      for (int a = 0; a < DEPTH; a++) begin
         @(negedge clock);
         ra1 = 5'(a);
         ra2 = 5'(DEPTH - 1 - a);
         #1;
         check_eq({tag, "_rd1"}, rd1, mdl[a]);
         check_eq({tag, "_rd2"}, rd2, mdl[DEPTH - 1 - a]);
      end
   endtask

   // mode 0: ready=1; mode 1: ready toggles + ignored restart;
   // mode 2: stall at r7 then write r7 on the accepting cycle; mode 3: reset at beat 10.
   task automatic run_dump(input int mode);
      int cyc, busy_cyc, stalls, xfer_cyc, done_cyc, exp_addr, st;
      bit stop;
      for (int i = 0; i < DEPTH; i++)
         sb.push_back('{addr: 5'(i), data: mdl[i]});
      @(negedge clock);
      dump_start = 1'b1;
      dump_ready = 1'b1;
      @(negedge clock);
      cyc = 0; busy_cyc = 0; stalls = 0; xfer_cyc = -10; done_cyc = -1;
      exp_addr = 0; st = 0; stop = 1'b0;
      while (!stop && cyc < 300) begin
         we = 1'b0;
         dump_start = 1'b0;
         dump_ready = 1'b1;
         case (mode)
            1: begin
               dump_ready = cyc[0];
               dump_start = (cyc == 10);
            end
            2: begin
               if (exp_addr == 7) begin
                  if (st < 2) begin
                     dump_ready = 1'b0;
                  end else begin
                     we = 1'b1; wa = 5'd7; wd = 32'hCAFE_F00D;
                     mdl[7] = wd;
                     if (sb.size() > 0) sb[0].data = wd;
                  end
                  st++;
               end
            end
            default: ;
         endcase
         #1;
         if (mode == 2 && exp_addr == 7)
            check_eq("dump_data_r7", dump_data, mdl[7]);
         if (mode == 3 && exp_addr == 10) begin
            reset_n = 1'b0;
            #1;
            check_eq("rst_valid", 32'(dump_valid), 32'd0);
            check_eq("rst_busy", 32'(dump_busy), 32'd0);
            check_eq("rst_addr", 32'(dump_addr), 32'd0);
            check_eq("rst_done", 32'(dump_done), 32'd0);
            stop = 1'b1;
         end else begin
            if (dump_busy) busy_cyc++;
            if (dump_valid) begin
               check_eq("run_addr", 32'(dump_addr), 32'(exp_addr));
               if (dump_ready) begin
                  xfer_cyc = cyc;
                  exp_addr++;
               end else begin
                  stalls++;
               end
            end
            if (dump_done) done_cyc = cyc;
            if (!dump_busy) begin
               stop = 1'b1;
            end else begin
               @(negedge clock);
               cyc++;
            end
         end
      end
      if (mode == 3) begin
         check_eq("rst_remaining_beats", 32'(sb.size()), 32'd22);
         sb.delete();
         for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
         repeat (2) begin
            @(negedge clock);
            #1;
            check_eq("rst_hold_done", 32'(dump_done), 32'd0);
         end
         reset_n = 1'b1;
         read_all("post_rst");
      end else begin
         check_eq("done_after_last", 32'(done_cyc), 32'(xfer_cyc + 1));
         check_eq("busy_cycles", 32'(busy_cyc), 32'(DEPTH + stalls + 1));
         check_eq("done_cleared", 32'(dump_done), 32'd0);
         check_eq("beats_left", 32'(sb.size()), 32'd0);
         sb.delete();
         if (mode == 1) begin
            check_eq("toggle_total", 32'(busy_cyc), 32'd65);
            repeat (3) begin
               @(negedge clock);
               #1;
               check_eq("no_queued_restart", 32'({dump_busy, dump_valid}), 32'd0);
            end
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
      dump_start = 1'b0; dump_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      repeat (2) @(negedge clock);
      #1;
      check_eq("reset_valid", 32'(dump_valid), 32'd0);
      check_eq("reset_busy", 32'(dump_busy), 32'd0);
      check_eq("reset_done", 32'(dump_done), 32'd0);
      check_eq("reset_addr", 32'(dump_addr), 32'd0);
      reset_n = 1'b1;
      read_all("init");

      // r0 discards writes, even through the bypass path.
      @(negedge clock);
      we = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF; ra1 = 5'd0;
      #1;
      check_eq("r0_bypass", rd1, 32'd0);
      @(negedge clock);
      we = 1'b0;
      #1;
      check_eq("r0_stored", rd1, 32'd0);

      @(negedge clock);
      we = 1'b1; wa = 5'd5; wd = 32'h1234_5678; ra1 = 5'd5; ra2 = 5'd6;
      mdl[5] = wd;
      #1;
      check_eq("bypass_rd1", rd1, 32'h1234_5678);
      check_eq("bypass_other", rd2, 32'd0);
      @(negedge clock);
      we = 1'b0;
      #1;
      check_eq("stored_rd1", rd1, 32'h1234_5678);

      for (int n = 1; n < DEPTH; n++) begin
         @(negedge clock);
         we = 1'b1; wa = 5'(n); wd = 32'(n) * 32'h0101_0101;
         mdl[n] = wd;
      end
      @(negedge clock);
      we = 1'b0;
      read_all("loaded");

      run_dump(0);
      run_dump(1);
      run_dump(2);
      run_dump(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
